// File: rtl/fetch_pkg.sv
// fetch_pkg: widths, constants and types shared by the fetch stage and its FIFOs
package fetch_pkg;
    localparam int PC_W = 27;
    localparam int INST_W = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PC_W-1:0] RESET_PC = 27'd16308;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
    typedef logic [PC_W-1:0] pc_t;
    typedef logic [INST_W-1:0] inst_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous clear
// Ports: push/din write, pop reads the head shown on dout, clear empties it,
// count/full/empty report occupancy. Push on a full FIFO is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int W = 8,
    parameter int D = 4,
    localparam int CW = $clog2(D) + 1
) (
    input  logic          clk,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(D);
    logic [W-1:0] r_mem [D];
    logic [AW-1:0] r_rd, r_wr;
    logic [CW-1:0] r_count;
    logic w_push, w_pop;
    always_comb begin
        empty = r_count == '0;
        full = r_count == CW'(D);
        w_pop = pop && !empty;
        w_push = push && (!full || w_pop);
        dout = r_mem[r_rd];
        count = r_count;
    end
    always_ff @(posedge clk) begin
        if (w_push && !clear) r_mem[r_wr] <= din;
    end
    always_ff @(posedge clk) begin
        if (clear) begin
            r_rd <= '0;
            r_wr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: issues instruction-memory reads for the current PC and pairs responses with their PCs for decode
// Ports: clk/rst (sync, active-high); pc/flush from the PC register, pc_adv back to it;
// imem_req_* request channel, imem_resp_* in-order responses; dec_* valid/ready output to decode.
module fetch_stage import fetch_pkg::*; (
    input  logic            clk,
    input  logic            rst,
    input  pc_t             pc,
    input  logic            flush,
    output logic            pc_adv,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-3:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  inst_t           imem_resp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output inst_t           dec_inst,
    output pc_t             dec_pc
);
    logic [CNT_W-1:0] r_drop_cnt, w_tag_count, w_data_count, w_inflight;
    logic [CNT_W:0] w_occupancy;
    logic w_req_valid, w_req_fire, w_resp_drop, w_resp_push, w_pop, w_clear;
    logic w_tag_full, w_tag_empty, w_data_full, w_data_empty, w_unused;
    pc_t w_tag_head;
    inst_t w_data_head;
    always_comb begin
        w_inflight = w_tag_count - w_data_count;
        // stale responses still to come occupy slots just like live tags
        w_occupancy = {1'b0, w_tag_count} + {1'b0, r_drop_cnt};
        w_req_valid = !rst && !flush && w_occupancy < (CNT_W + 1)'(DEPTH);
        w_req_fire = w_req_valid && imem_req_ready;
        w_resp_drop = imem_resp_valid && r_drop_cnt != '0;
        // a response with nothing in flight is a protocol error and is ignored
        w_resp_push = imem_resp_valid && !flush && r_drop_cnt == '0 && w_inflight != '0;
        w_pop = dec_valid && dec_ready && !flush;
        w_clear = rst || flush;
        pc_adv = !rst && (w_req_fire || flush);
        imem_req_valid = w_req_valid;
        imem_req_addr = pc[PC_W-1:2];
        dec_valid = !rst && !w_data_empty;
        dec_inst = rst ? '0 : w_data_head;
        dec_pc = rst ? '0 : w_tag_head;
        w_unused = &{1'b0, w_tag_full, w_tag_empty, w_data_full, pc[1:0]};
    end
    always_ff @(posedge clk) begin
        if (rst) r_drop_cnt <= '0;
        else if (flush) r_drop_cnt <= r_drop_cnt + w_inflight - CNT_W'(imem_resp_valid);
        else if (w_resp_drop) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
    end
    sync_fifo #(.W(PC_W), .D(DEPTH)) u_tags (
        .clk(clk), .push(w_req_fire), .pop(w_pop), .clear(w_clear), .din(pc),
        .dout(w_tag_head), .count(w_tag_count), .full(w_tag_full), .empty(w_tag_empty)
    );
    sync_fifo #(.W(INST_W), .D(DEPTH)) u_data (
        .clk(clk), .push(w_resp_push), .pop(w_pop), .clear(w_clear), .din(imem_resp_data),
        .dout(w_data_head), .count(w_data_count), .full(w_data_full), .empty(w_data_empty)
    );
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
        !(imem_resp_valid && w_inflight == '0 && r_drop_cnt == '0));
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized/directed bench for fetch_stage against a request-queue reference model
module tb_fetch_stage;
    import fetch_pkg::*;
    typedef struct { pc_t pc; inst_t inst; int due; bit stale; } req_t;
    typedef struct { pc_t pc; inst_t inst; } pair_t;
    logic clk = 0, rst = 1, flush = 0, pc_adv, imem_req_valid, imem_req_ready = 0;
    logic imem_resp_valid = 0, dec_valid, dec_ready = 0;
    logic [PC_W-3:0] imem_req_addr;
    pc_t pc = RESET_PC, dec_pc;
    inst_t imem_resp_data = '0, dec_inst;
    req_t mem_q[$];
    pair_t dec_q[$];
    int n_tests = 0, n_fail = 0, cyc_n = 0, seq = 0, lat_max = 0;
    int n_fire = 0, n_pop = 0, n_adv = 0;
    always #5 clk = ~clk;
    fetch_stage dut (
        .clk(clk), .rst(rst), .pc(pc), .flush(flush), .pc_adv(pc_adv),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_inst(dec_inst), .dec_pc(dec_pc)
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic inst_t mk(input pc_t p, input int s);
        return inst_t'(s * 32'h9E37_79B1) ^ inst_t'(p);
    endfunction
    // One clock cycle: drive inputs, check outputs mid-cycle against the model, advance the model.
    task automatic tick(input bit fl, input bit rr, input bit dr, input int rp);
        int live, stale;
        bit exp_rv, fire, resp, popd;
        logic [31:0] rnd;
        pc_t tgt;
        req_t r;
        stale = 0;
        foreach (mem_q[i]) if (mem_q[i].stale) stale++;
        live = mem_q.size() - stale + dec_q.size();
        resp = !rst && mem_q.size() > 0 && mem_q[0].due <= cyc_n && $urandom_range(99) < rp;
        flush = fl;
        imem_req_ready = rr;
        dec_ready = dr;
        imem_resp_valid = resp;
        imem_resp_data = resp ? mem_q[0].inst : inst_t'($urandom);
        exp_rv = !rst && !fl && live + stale < DEPTH;
        fire = exp_rv && rr;
        @(negedge clk);
        if (rst) begin
            chk("rst_pc_adv", pc_adv, 0);
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_dec_valid", dec_valid, 0);
            chk("rst_dec_inst", dec_inst, 0);
            chk("rst_dec_pc", dec_pc, 0);
        end else begin
            n_fire += int'(imem_req_valid && imem_req_ready);
            n_pop += int'(dec_valid && dec_ready);
            n_adv += int'(pc_adv);
            chk("req_valid", imem_req_valid, exp_rv);
            chk("pc_adv", pc_adv, fire || fl);
            chk("req_addr", imem_req_addr, pc[PC_W-1:2]);
            chk("drop_cnt", dut.r_drop_cnt, stale);
            chk("dec_valid", dec_valid, dec_q.size() > 0);
            if (dec_q.size() > 0) begin
                chk("dec_pc", dec_pc, dec_q[0].pc);
                chk("dec_inst", dec_inst, dec_q[0].inst);
            end
        end
        rnd = $urandom;
        tgt = {rnd[PC_W-3:0], 2'b00};
        if (rst) begin
            mem_q.delete();
            dec_q.delete();
        end else begin
            popd = dr && dec_q.size() > 0 && !fl;
            if (popd) void'(dec_q.pop_front());
            if (resp) begin
                r = mem_q.pop_front();
                if (!r.stale && !fl) dec_q.push_back('{pc: r.pc, inst: r.inst});
            end
            if (fl) begin
                dec_q.delete();
                foreach (mem_q[i]) mem_q[i].stale = 1;
            end
            if (fire) begin
                seq++;
                mem_q.push_back('{pc: pc, inst: mk(pc, seq), due: cyc_n + 1 + $urandom_range(lat_max), stale: 0});
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (rst) pc = RESET_PC;
        else if (fl) pc = tgt;
        else if (fire) pc = pc + 4;
    endtask
    initial begin
        @(posedge clk);
        #1;
        repeat (2) tick(0, 1, 1, 100);
        rst = 0;
        // zero-wait streaming
        n_pop = 0;
        n_adv = 0;
        repeat (20) tick(0, 1, 1, 100);
        chk("stream_pops", n_pop, 18);
        chk("stream_adv", n_adv, 20);
        repeat (3) tick(0, 0, 1, 100);
        // decode backpressure
        n_fire = 0;
        repeat (10) tick(0, 1, 0, 100);
        chk("bp_fires", n_fire, 4);
        n_pop = 0;
        repeat (5) tick(0, 0, 1, 100);
        chk("bp_drain", n_pop, 4);
        // flush with three requests outstanding
        repeat (3) tick(0, 1, 1, 0);
        tick(1, 1, 1, 0);
        chk("flush3_drop", dut.r_drop_cnt, 3);
        repeat (12) tick(0, 1, 1, 100);
        repeat (6) tick(0, 0, 1, 100);
        // flush coinciding with a response and a decode pop
        tick(0, 1, 0, 100);
        tick(0, 1, 0, 100);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(1, 1, 1, 100);
        chk("flush_coinc_drop", dut.r_drop_cnt, 1);
        chk("flush_coinc_valid", dec_valid, 0);
        // memory stall
        n_adv = 0;
        repeat (5) tick(0, 0, 1, 100);
        chk("stall_adv", n_adv, 0);
        // randomized traffic
        lat_max = 3;
        repeat (300) tick($urandom_range(99) < 5, $urandom_range(1), $urandom_range(3) != 0, 60);
        // reset mid-stream
        lat_max = 0;
        repeat (4) tick(0, 1, 0, 100);
        rst = 1;
        tick(0, 1, 1, 100);
        rst = 0;
        chk("post_rst_drop", dut.r_drop_cnt, 0);
        chk("post_rst_valid", dec_valid, 0);
        chk("post_rst_addr", imem_req_addr, RESET_PC[PC_W-1:2]);
        repeat (8) tick(0, 1, 1, 100);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the program-counter register.
- Takes the current PC and issues word reads to instruction memory over a valid/ready request channel with in-order, variable-latency responses.
- Pairs each returned instruction with its PC and presents the pair to decode through a DEPTH-entry queue with a valid/ready handshake.
- Generates the PC-advance strobe and discards in-flight fetches on a redirect (flush).

Parameters:
- PC_W, 27, PC width in bytes; PC is always word-aligned (bits [1:0] = 0).
- INST_W, 32, instruction width.
- DEPTH, 4, fetch-queue entries and maximum outstanding requests; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- pc  in  PC_W  current PC from the PC register.
- flush  in  1  redirect: the PC register loads the new target this cycle.
- pc_adv  out  1  drives the PC register's advance enable (n_stall); equals req_fire OR flush.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  PC_W-2  word address, equal to pc[PC_W-1:2].
- imem_resp_valid  in  1  response valid; responses arrive in order, no earlier than 1 cycle after acceptance.
- imem_resp_data  in  INST_W  instruction word.
- dec_valid  out  1  instruction available to decode.
- dec_ready  in  1  decode consumes the instruction.
- dec_inst  out  INST_W  instruction.
- dec_pc  out  PC_W  PC of dec_inst.

Behaviour:
- Structures:
  - tag FIFO (PCs of accepted requests), DEPTH entries.
  - data FIFO (returned instructions), DEPTH entries.
  - drop_cnt: counter of responses to discard, width clog2(DEPTH)+1.
  - inflight = tag_count - data_count.
- Request issue:
  - imem_req_valid = !flush AND (tag_count + drop_cnt < DEPTH).
  - req_fire = imem_req_valid AND imem_req_ready.
  - On req_fire, push pc into the tag FIFO.
  - imem_req_addr is combinational from pc.
  - Once raised, imem_req_valid stays high with the same address until fire or flush.
- PC advance:
  - pc_adv = req_fire OR flush.
  - The PC register therefore steps +4 only on an accepted fetch, and loads the redirect target on a flush.
- Response handling:
  - If imem_resp_valid and drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise push imem_resp_data into the data FIFO.
  - A response with inflight = 0 and drop_cnt = 0 is a protocol error; it is ignored and caught by an assertion.
- Decode output:
  - dec_valid = data FIFO non-empty.
  - dec_inst = data FIFO head; dec_pc = tag FIFO head.
  - dec_valid AND dec_ready pops both FIFOs in the same cycle.
  - Outputs are combinational from the FIFO heads, giving 1-cycle latency from response to dec_valid.
  - dec_inst/dec_pc hold their values while dec_valid is high and dec_ready is low.
- Flush (highest priority):
  - Both FIFOs are cleared; no push or pop takes effect that cycle.
  - drop_cnt <= drop_cnt + inflight - (imem_resp_valid ? 1 : 0).
  - A response arriving in the flush cycle is discarded.
  - dec_valid is 0 in the cycle after a flush.
  - A dec_ready handshake in the flush cycle still counts as consumed.
- Simultaneous events:
  - Push and pop in the same cycle on a full FIFO are legal; the count is unchanged.
  - Request fire and response in the same cycle are both processed.
- Full condition: with tag_count + drop_cnt = DEPTH, no request is issued and pc_adv = 0, which stalls the PC.
- Reset (synchronous): FIFOs empty, drop_cnt = 0. During reset: pc_adv = 0, imem_req_valid = 0, dec_valid = 0, dec_inst = 0, dec_pc = 0.
- Reset mid-operation: in-flight memory responses are not tracked. The memory system is reset in the same cycle, so no stale response arrives after reset.

Decomposition:
- fetch_pkg:
  - PC_W, INST_W, DEPTH.
  - RESET_PC = 27'd16308 (loader start, shared with the PC register).
  - NOP_INST constant.
  - typedef pc_t (logic [PC_W-1:0]) and inst_t (logic [INST_W-1:0]).
- Sub-module sync_fifo, parameterised by width/depth:
  - ports: push, pop, clear, din, dout, count, full, empty.
  - instantiated twice: tags (PC_W wide) and data (INST_W wide).
- fetch_stage holds only the issue logic, drop_cnt, and flush control.

Test Plan:
- Zero-wait streaming: imem_req_ready = 1, responses 1 cycle after acceptance, dec_ready = 1, pc starts at 16308 → dec_pc sequence 16308, 16312, 16316…; one instruction per cycle after a 2-cycle fill; pc_adv continuously 1.
- Backpressure: dec_ready = 0 for 10 cycles → exactly 4 requests accepted, then imem_req_valid = 0 and pc_adv = 0. Releasing dec_ready drains 4 instructions in order with their matching PCs.
- Flush with 3 in flight: 3 accepted and 0 returned, then flush → drop_cnt = 3. The next 3 responses are discarded; the first dec_pc afterwards equals the redirect target; no stale instruction reaches decode.
- Flush coincident with a response and a decode pop: 2 in flight, response arrives in the flush cycle → drop_cnt = 1, both FIFOs empty, dec_valid = 0 in the next cycle.
- Memory stall: imem_req_ready = 0 for 5 cycles → imem_req_valid stays high with a stable imem_req_addr and pc_adv = 0 throughout; the PC does not change.
- Reset mid-stream: rst asserted with FIFOs non-empty → next cycle dec_valid = 0, imem_req_valid = 0, drop_cnt = 0; fetching resumes from 16308 after reset deasserts.
